// File: rtl/mem_access_unit.sv
// Load/store initiator: takes one RV32I memory request at a time, drives the
// byte-masked RAM strobes, and returns aligned, extended load data or an error.
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 1536
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [1:0]  rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_ILL   = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t r_state, w_state_nxt;

   logic          r_we, w_we_nxt;
   logic [2:0]    r_funct3, w_funct3_nxt;
   logic [1:0]    r_addr_lo, w_addr_lo_nxt;
   logic          r_req_ready, w_req_ready_nxt;
   logic          r_rsp_valid, w_rsp_valid_nxt;
   logic [1:0]    r_rsp_err, w_rsp_err_nxt;
   logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
   logic          r_mem_rstrb, w_mem_rstrb_nxt;
   logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [MW-1:0] r_mem_wmask, w_mem_wmask_nxt;

   logic          w_illegal, w_misalign, w_range;
   logic [1:0]    w_req_err;
   logic [7:0]    w_ld_byte;
   logic [15:0]   w_ld_half;
   logic [DW-1:0] w_ld_data;

   // Request classification; illegal beats misaligned beats out of range
   assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_range    = 32'(req_addr[31:2]) >= MEM_WORDS;
   assign w_req_err  = w_illegal  ? ERR_ILL   :
                       w_misalign ? ERR_ALIGN :
                       w_range    ? ERR_RANGE : ERR_OK;

   // Load alignment and sign/zero extension of the RAM word
   assign w_ld_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
   assign w_ld_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];
   always_comb begin
      w_ld_data = mem_rdata;
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_data = {24'd0, w_ld_byte};
         3'b101:  w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = mem_rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and next values of the registered outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_we_nxt        = r_we;
      w_funct3_nxt    = r_funct3;
      w_addr_lo_nxt   = r_addr_lo;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = r_rsp_err;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_rstrb_nxt = 1'b0;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wmask_nxt = '0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_we_nxt      = req_we;
               w_funct3_nxt  = req_funct3;
               w_addr_lo_nxt = req_addr[1:0];
               if (w_req_err != ERR_OK) begin
                  w_state_nxt     = RESP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = w_req_err;
                  w_rsp_rdata_nxt = '0;
               end else begin
                  w_state_nxt    = ISSUE;
                  w_mem_addr_nxt = req_addr;
                  if (req_we) begin
                     case (req_funct3[1:0])
                        2'b00: begin
                           w_mem_wmask_nxt = 4'(4'b0001 << req_addr[1:0]);
                           w_mem_wdata_nxt = {4{req_wdata[7:0]}};
                        end
                        2'b01: begin
                           w_mem_wmask_nxt = 4'(4'b0011 << {req_addr[1], 1'b0});
                           w_mem_wdata_nxt = {2{req_wdata[15:0]}};
                        end
                        default: begin
                           w_mem_wmask_nxt = 4'b1111;
                           w_mem_wdata_nxt = req_wdata;
                        end
                     endcase
                  end else begin
                     w_mem_rstrb_nxt = 1'b1;
                  end
               end
            end
         end
         ISSUE: begin
            if (r_we) begin
               w_state_nxt     = RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = ERR_OK;
               w_rsp_rdata_nxt = '0;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = ERR_OK;
            w_rsp_rdata_nxt = w_ld_data;
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_req_ready_nxt = (w_state_nxt == IDLE);
   end

   // Output and request-context registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= ERR_OK;
         r_rsp_rdata <= '0;
         r_mem_addr  <= '0;
         r_mem_rstrb <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
      end else begin
         r_we        <= w_we_nxt;
         r_funct3    <= w_funct3_nxt;
         r_addr_lo   <= w_addr_lo_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_rstrb <= w_mem_rstrb_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wmask <= w_mem_wmask_nxt;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_rstrb = r_mem_rstrb;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;

endmodule
